// File: rtl/csr_counters.sv
// Read-only counter CSR responder: 64-bit cycle/time/instret counters with a
// combinational CSR read port and a debug preload port.
module csr_counters #(
  parameter int unsigned TIME_DIV = 1,
  parameter logic [31:0] HART_ID  = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_csr_id,
  output logic [31:0] o_csr_data,
  output logic        o_csr_valid,
  input  logic        i_instr_retired,
  input  logic        i_dbg_load,
  input  logic [1:0]  i_dbg_sel,
  input  logic [63:0] i_dbg_value
);

  localparam int PW = $clog2(TIME_DIV) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TIME_DIV - 1);

  logic [63:0]   cycle_q, cycle_d;
  logic [63:0]   time_q, time_d;
  logic [63:0]   instret_q, instret_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          time_tick;

  // Loads override the increment of the selected counter only.
  always_comb begin
    time_tick  = (prescale_q == PS_LAST);
    cycle_d    = cycle_q + 64'd1;
    instret_d  = i_instr_retired ? instret_q + 64'd1 : instret_q;
    time_d     = time_tick ? time_q + 64'd1 : time_q;
    prescale_d = time_tick ? '0 : prescale_q + PW'(1);
    if (i_dbg_load) begin
      case (i_dbg_sel)
        2'd0: cycle_d = i_dbg_value;
        2'd1: begin
          time_d     = i_dbg_value;
          prescale_d = '0;
        end
        2'd2: instret_d = i_dbg_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_q    <= '0;
      time_q     <= '0;
      instret_q  <= '0;
      prescale_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      time_q     <= time_d;
      instret_q  <= instret_d;
      prescale_q <= prescale_d;
    end
  end

  // Zero-latency read mux; unimplemented addresses read as 0 and invalid.
  always_comb begin
    o_csr_data  = 32'd0;
    o_csr_valid = 1'b0;
    case (i_csr_id)
      12'hC00, 12'hB00: begin
        o_csr_data  = cycle_q[31:0];
        o_csr_valid = 1'b1;
      end
      12'hC80, 12'hB80: begin
        o_csr_data  = cycle_q[63:32];
        o_csr_valid = 1'b1;
      end
      12'hC01: begin
        o_csr_data  = time_q[31:0];
        o_csr_valid = 1'b1;
      end
      12'hC81: begin
        o_csr_data  = time_q[63:32];
        o_csr_valid = 1'b1;
      end
      12'hC02, 12'hB02: begin
        o_csr_data  = instret_q[31:0];
        o_csr_valid = 1'b1;
      end
      12'hC82, 12'hB82: begin
        o_csr_data  = instret_q[63:32];
        o_csr_valid = 1'b1;
      end
      12'hF14: begin
        o_csr_data  = HART_ID;
        o_csr_valid = 1'b1;
      end
      12'hF11, 12'hF12, 12'hF13: o_csr_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
